// File: rtl/counter_pkg.sv
// counter_pkg: shared mode constants and load clamping helper for the up/down counter
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SATURATE = 1;
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
    return value > max ? max : value;
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles into a one-cycle tick every PRESCALE enabled cycles
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  if (PRESCALE == 1) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset_n, clear};
    assign tick = enable;
  end else begin : g_div
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] phase_q, phase_d;
    assign tick = enable && phase_q == PW'(PRESCALE - 1);
    // next phase: restart on clear or tick, hold while disabled
    always_comb phase_d = clear || tick ? '0 : enable ? phase_q + 1'b1 : phase_q;
    // phase register
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) phase_q <= '0;
      else phase_q <= phase_d;
  end
endmodule

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with wrap/saturate, load/clear, prescaler and boundary flags
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 255,
  parameter int          MODE      = 0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             terminal,
  output logic             overflow
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  logic [WIDTH-1:0] count_q, count_d, load_clamped, stepped, bound_val;
  logic terminal_q, terminal_d, overflow_q, overflow_d, tick, boundary;
  counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clock(clock),
    .reset_n(reset_n),
    .clear(clear | load),
    .enable(enable),
    .tick(tick)
  );
  assign at_max = count_q == MAX;
  assign at_zero = count_q == '0;
  assign count = count_q;
  assign terminal = terminal_q;
  assign overflow = overflow_q;
  // next state: clear beats load beats step; boundary steps wrap or hold
  always_comb begin
    load_clamped = WIDTH'(clamp_load(32'(load_value), 32'(MAX_COUNT)));
    boundary = tick && (up ? at_max : at_zero);
    stepped = up ? count_q + 1'b1 : count_q - 1'b1;
    bound_val = MODE == MODE_SATURATE ? count_q : up ? '0 : MAX;
    count_d = clear ? '0 : load ? load_clamped : !tick ? count_q : boundary ? bound_val : stepped;
    terminal_d = !clear && !load && boundary;
    overflow_d = !clear && (overflow_q || terminal_d);
  end
  // count and flag registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count_q <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed and random checks of three counter configurations against a behavioural model
module tb_updown_counter;
  logic clock = 1'b0;
  logic reset_n, clear, load, enable, up;
  logic [3:0] load_value;
  logic [3:0] cnt [3];
  logic amax [3], azero [3], term [3], ovf [3];
  int checks = 0, errors = 0;
  int m_cnt [3], m_pre [3], m_term [3], m_ovf [3];
  int pres [3] = '{1, 1, 4};
  int sat [3] = '{0, 1, 0};
  localparam int MAXV = 9;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    updown_counter #(.WIDTH(4), .MAX_COUNT(9), .MODE(g == 1 ? 1 : 0), .PRESCALE(g == 2 ? 4 : 1)) dut (
      .clock(clock), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
      .enable(enable), .up(up), .count(cnt[g]), .at_max(amax[g]), .at_zero(azero[g]),
      .terminal(term[g]), .overflow(ovf[g])
    );
  end

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_term[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_edge();
    int n;
    bit tk;
    if (!reset_n) begin
      model_zero();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_term[i] = 0;
      if (clear) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = int'(load_value) > MAXV ? MAXV : int'(load_value);
        m_pre[i] = 0;
      end else if (enable) begin
        m_pre[i] = (m_pre[i] + 1) % pres[i];
        tk = m_pre[i] == 0;
        if (tk) begin
          n = m_cnt[i] + (up ? 1 : -1);
          if (n < 0 || n > MAXV) begin
            m_term[i] = 1;
            m_ovf[i] = 1;
            if (!sat[i]) m_cnt[i] = n < 0 ? MAXV : 0;
          end else m_cnt[i] = n;
        end
      end
    end
  endtask

  task automatic check_all(string ph);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_d%0d_count", ph, i), int'(cnt[i]), m_cnt[i]);
      check($sformatf("%s_d%0d_at_max", ph, i), int'(amax[i]), int'(m_cnt[i] == MAXV));
      check($sformatf("%s_d%0d_at_zero", ph, i), int'(azero[i]), int'(m_cnt[i] == 0));
      check($sformatf("%s_d%0d_terminal", ph, i), int'(term[i]), m_term[i]);
      check($sformatf("%s_d%0d_overflow", ph, i), int'(ovf[i]), m_ovf[i]);
    end
  endtask

  task automatic step(string ph);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all(ph);
  endtask

  task automatic set_in(bit c, bit l, int lv, bit e, bit u);
    clear = c; load = l; load_value = 4'(lv); enable = e; up = u;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_zero();
    step("rst");
    step("rst");
    reset_n = 1'b1;
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 12; k++) step("up12");
    check("t1_wrap_count", int'(cnt[0]), 2);
    check("t1_sat_count", int'(cnt[1]), 9);
    check("t1_pre4_count", int'(cnt[2]), 3);
    check("t1_wrap_ovf", int'(ovf[0]), 1);
    set_in(1, 0, 0, 0, 0);
    step("clr");
    set_in(0, 0, 0, 1, 0);
    step("down0");
    check("t2_wrap_to_max", int'(cnt[0]), 9);
    check("t2_terminal", int'(term[0]), 1);
    check("t2_overflow", int'(ovf[0]), 1);
    set_in(1, 0, 0, 0, 0);
    step("clr2");
    check("t2_clr_count", int'(cnt[0]), 0);
    check("t2_clr_ovf", int'(ovf[0]), 0);
    set_in(0, 1, 9, 0, 0);
    step("ld9");
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step("satup");
      check("t3_sat_hold_max", int'(cnt[1]), 9);
      check("t3_sat_term_hi", int'(term[1]), 1);
    end
    check("t3_sat_ovf", int'(ovf[1]), 1);
    set_in(0, 1, 0, 0, 0);
    step("ld0");
    set_in(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step("satdn");
      check("t3_sat_hold_zero", int'(cnt[1]), 0);
      check("t3_sat_term_lo", int'(term[1]), 1);
    end
    set_in(1, 0, 0, 0, 0);
    step("clr3");
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 12; k++) step("pre");
    check("t4_three_steps", int'(cnt[2]), 3);
    for (int k = 0; k < 2; k++) step("pre_a");
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step("pre_hold");
    check("t4_hold_no_step", int'(cnt[2]), 3);
    set_in(0, 0, 0, 1, 1);
    step("pre_b");
    check("t4_phase_kept_a", int'(cnt[2]), 3);
    step("pre_c");
    check("t4_phase_kept_b", int'(cnt[2]), 4);
    set_in(0, 1, 15, 0, 0);
    step("ld15");
    check("t5_clamp", int'(cnt[0]), 9);
    set_in(1, 1, 5, 0, 0);
    step("ldclr");
    check("t5_clear_wins", int'(cnt[0]), 0);
    set_in(0, 1, 5, 1, 1);
    step("ldtick");
    check("t5_load_over_step", int'(cnt[0]), 5);
    check("t5_load_no_term", int'(term[0]), 0);
    set_in(1, 0, 0, 0, 0);
    step("clr4");
    set_in(0, 0, 0, 1, 0);
    step("ovfset");
    set_in(0, 1, 7, 0, 0);
    step("ld7");
    check("t6_pre_count", int'(cnt[0]), 7);
    check("t6_pre_ovf", int'(ovf[0]), 1);
    set_in(0, 0, 0, 1, 1);
    #2 reset_n = 1'b0;
    model_zero();
    #1 check_all("async");
    step("inrst");
    reset_n = 1'b1;
    step("resume");
    check("t6_resume", int'(cnt[0]), 1);
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(15),
             $urandom_range(3) != 0, $urandom_range(1) == 1);
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
